// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues imem requests, fills the IF/ID register and
// steers next_PC for stalls, memory wait states and redirects.
//
// state   | meaning
// IDLE    | no request outstanding; next cycle requests the current PC
// WAIT    | request to req_addr outstanding
// HOLD    | returned word parked in skid while IF/ID is stalled
// DISCARD | request outstanding whose data is dropped after a redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic [31:0] next_PC,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DISCARD} state_t;

  state_t      state, state_nx;
  logic [31:0] req_addr, req_addr_nx;
  logic [31:0] skid, skid_nx;
  logic [31:0] instr_nx, pc_nx, pc4_nx, cnt_nx;
  logic        valid_nx;
  logic [31:0] npc;
  logic        dlv;
  logic [31:0] dlv_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      req_addr    <= 32'h0;
      skid        <= 32'h0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
      fetch_cnt   <= 32'h0;
    end else begin
      state       <= state_nx;
      req_addr    <= req_addr_nx;
      skid        <= skid_nx;
      if_id_instr <= instr_nx;
      if_id_pc    <= pc_nx;
      if_id_pc4   <= pc4_nx;
      if_id_valid <= valid_nx;
      fetch_cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    req_addr_nx = req_addr;
    skid_nx     = skid;
    instr_nx    = if_id_instr;
    pc_nx       = if_id_pc;
    pc4_nx      = if_id_pc4;
    valid_nx    = if_id_valid;
    cnt_nx      = fetch_cnt;
    npc         = PC;
    dlv         = 1'b0;
    dlv_data    = imem_rdata;

    if (redirect) begin
      // Redirect wins over stall and ready; an in-flight request without data is drained in DISCARD.
      npc      = branch_target;
      instr_nx = NOP_INSTR;
      valid_nx = 1'b0;
      skid_nx  = 32'h0;
      case (state)
        WAIT: begin
          if (imem_ready) req_addr_nx = branch_target;
          else            state_nx    = DISCARD;
        end
        DISCARD: begin
          if (imem_ready) begin
            state_nx    = WAIT;
            req_addr_nx = branch_target;
          end
        end
        default: begin
          state_nx    = WAIT;
          req_addr_nx = branch_target;
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          state_nx    = WAIT;
          req_addr_nx = PC;
        end
        WAIT: begin
          if (imem_ready) begin
            if (!stall) begin
              dlv = 1'b1;
            end else begin
              skid_nx  = imem_rdata;
              state_nx = HOLD;
            end
          end else if (!stall) begin
            instr_nx = NOP_INSTR;
            valid_nx = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            dlv      = 1'b1;
            dlv_data = skid;
            state_nx = WAIT;
          end
        end
        DISCARD: begin
          if (imem_ready) begin
            state_nx    = WAIT;
            req_addr_nx = PC;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    if (dlv) begin
      instr_nx    = dlv_data;
      pc_nx       = req_addr;
      pc4_nx      = req_addr + 32'd4;
      valid_nx    = 1'b1;
      cnt_nx      = fetch_cnt + 32'd1;
      npc         = PC + 32'd4;
      req_addr_nx = PC + 32'd4;
    end
  end

  assign next_PC   = reset ? npc : RESET_PC;
  assign imem_req  = (state == WAIT) || (state == DISCARD);
  assign imem_addr = req_addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table plus an in-order delivery
// scoreboard, then wrap-around and asynchronous reset sequences.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_q = 32'h0;
  logic [31:0] next_PC;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4, fetch_cnt;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .PC(pc_q), .next_PC(next_PC),
    .stall(stall), .redirect(redirect), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pc_q <= next_PC;
  assign imem_rdata = imem_addr ^ KEY;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc = a;
    e.instr = a ^ KEY;
    sb.push_back(e);
  endtask

  // Each fetch_cnt step must deliver exactly the next expected instruction.
  logic [31:0] last_cnt = 32'h0;
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      last_cnt = 32'h0;
    end else if (fetch_cnt !== last_cnt) begin
      exp_t e;
      chk("dlv_cnt_step", fetch_cnt, last_cnt + 32'd1);
      last_cnt = fetch_cnt;
      if (sb.size() == 0) begin
        chk("dlv_unexpected", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("dlv_pc", if_id_pc, e.pc);
        chk("dlv_pc4", if_id_pc4, e.pc + 32'd4);
        chk("dlv_instr", if_id_instr, e.instr);
        chk("dlv_valid", {31'h0, if_id_valid}, 32'h1);
      end
    end
  end

  typedef struct {
    logic        st, rd, rdy, dl;
    logic [31:0] tg;
    logic        rq;
    logic [31:0] ad, nx;
    logic        vl;
    logic [31:0] ip, cn;
  } vec_t;

  function automatic vec_t v(input logic st, rd, rdy, dl, input logic [31:0] tg,
                             input logic rq, input logic [31:0] ad, nx,
                             input logic vl, input logic [31:0] ip, cn);
    vec_t r;
    r.st = st; r.rd = rd; r.rdy = rdy; r.dl = dl; r.tg = tg;
    r.rq = rq; r.ad = ad; r.nx = nx; r.vl = vl; r.ip = ip; r.cn = cn;
    return r;
  endfunction

  vec_t vt[28];

  initial begin
    // st rd rdy dl target | req addr next_PC | valid if_pc cnt
    vt[0]  = v(0,0,0,0,'h0,   0,'h0,  'h0,   0,'h0,  0);
    vt[1]  = v(0,0,0,0,'h0,   1,'h0,  'h0,   0,'h0,  0);
    vt[2]  = v(0,0,1,1,'h0,   1,'h0,  'h4,   0,'h0,  0);
    vt[3]  = v(0,0,0,0,'h0,   1,'h4,  'h4,   1,'h0,  1);
    vt[4]  = v(0,0,1,1,'h0,   1,'h4,  'h8,   0,'h0,  1);
    vt[5]  = v(0,0,0,0,'h0,   1,'h8,  'h8,   1,'h4,  2);
    vt[6]  = v(0,0,0,0,'h0,   1,'h8,  'h8,   0,'h4,  2);
    vt[7]  = v(0,0,0,0,'h0,   1,'h8,  'h8,   0,'h4,  2);
    vt[8]  = v(0,0,1,1,'h0,   1,'h8,  'hC,   0,'h4,  2);
    vt[9]  = v(0,0,1,1,'h0,   1,'hC,  'h10,  1,'h8,  3);
    vt[10] = v(1,0,1,1,'h0,   1,'h10, 'h10,  1,'hC,  4);
    vt[11] = v(1,0,0,0,'h0,   0,'h10, 'h10,  1,'hC,  4);
    vt[12] = v(0,0,0,0,'h0,   0,'h10, 'h14,  1,'hC,  4);
    vt[13] = v(1,0,0,0,'h0,   1,'h14, 'h14,  1,'h10, 5);
    vt[14] = v(0,0,0,0,'h0,   1,'h14, 'h14,  1,'h10, 5);
    vt[15] = v(0,1,0,0,'h100, 1,'h14, 'h100, 0,'h10, 5);
    vt[16] = v(0,0,0,0,'h0,   1,'h14, 'h100, 0,'h10, 5);
    vt[17] = v(0,0,1,0,'h0,   1,'h14, 'h100, 0,'h10, 5);
    vt[18] = v(0,0,1,1,'h0,   1,'h100,'h104, 0,'h10, 5);
    vt[19] = v(0,1,1,0,'h200, 1,'h104,'h200, 1,'h100,6);
    vt[20] = v(1,0,1,0,'h0,   1,'h200,'h200, 0,'h100,6);
    vt[21] = v(1,1,0,0,'h300, 0,'h200,'h300, 0,'h100,6);
    vt[22] = v(0,0,1,1,'h0,   1,'h300,'h304, 0,'h100,6);
    vt[23] = v(0,1,0,0,'h400, 1,'h304,'h400, 1,'h300,7);
    vt[24] = v(0,1,0,0,'h500, 1,'h304,'h500, 0,'h300,7);
    vt[25] = v(0,0,1,0,'h0,   1,'h304,'h500, 0,'h300,7);
    vt[26] = v(0,0,1,1,'h0,   1,'h500,'h504, 0,'h300,7);
    vt[27] = v(0,0,0,0,'h0,   1,'h504,'h504, 1,'h500,8);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_next_pc", next_PC, 32'h0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_req", {31'h0, imem_req}, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 28; i++) begin
      stall = vt[i].st;
      redirect = vt[i].rd;
      branch_target = vt[i].tg;
      imem_ready = vt[i].rdy;
      if (vt[i].dl) push(vt[i].ad);
      #1;
      chk($sformatf("r%0d_req", i), {31'h0, imem_req}, {31'h0, vt[i].rq});
      chk($sformatf("r%0d_addr", i), imem_addr, vt[i].ad);
      chk($sformatf("r%0d_next_pc", i), next_PC, vt[i].nx);
      chk($sformatf("r%0d_valid", i), {31'h0, if_id_valid}, {31'h0, vt[i].vl});
      chk($sformatf("r%0d_if_pc", i), if_id_pc, vt[i].ip);
      chk($sformatf("r%0d_cnt", i), fetch_cnt, vt[i].cn);
      if (!vt[i].vl) chk($sformatf("r%0d_nop", i), if_id_instr, NOP);
      @(negedge clk);
    end

    // Address wrap at the top of the address space.
    stall = 1'b0;
    redirect = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    imem_ready = 1'b1;
    #1 chk("wrap_redirect_next_pc", next_PC, 32'hFFFF_FFFC);
    @(negedge clk);
    redirect = 1'b0;
    push(32'hFFFF_FFFC);
    #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_next_pc", next_PC, 32'h0);
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    chk("wrap_if_pc4", if_id_pc4, 32'h0);
    chk("wrap_if_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_req", {31'h0, imem_req}, 32'h1);

    // Asynchronous reset mid-request, between clock edges.
    #1 reset = 1'b0;
    #1;
    chk("arst_req", {31'h0, imem_req}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_next_pc", next_PC, 32'h0);
    chk("arst_instr", if_id_instr, NOP);
    chk("arst_pc", if_id_pc, 32'h0);
    chk("arst_pc4", if_id_pc4, 32'h0);
    chk("arst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("arst_cnt", fetch_cnt, 32'h0);
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("arst_ready_ignored_cnt", fetch_cnt, 32'h0);
    chk("arst_ready_ignored_req", {31'h0, imem_req}, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    imem_ready = 1'b0;
    #1;
    chk("rel_idle_req", {31'h0, imem_req}, 32'h0);
    chk("rel_idle_next_pc", next_PC, 32'h0);
    @(negedge clk);
    #1;
    chk("rel_first_req", {31'h0, imem_req}, 32'h1);
    chk("rel_first_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    push(32'h0);
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    chk("rel_first_cnt", fetch_cnt, 32'h1);
    @(negedge clk);
    chk("sb_drained", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, value driven on next_PC while reset is asserted.
REQ-002 Parameter NOP_INSTR, 32'h0000_0000, value loaded into if_id_instr on reset and flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 PC  input  32  current PC from prog_counter.
REQ-006 next_PC  output  32  combinational; prog_counter registers it every rising edge.
REQ-007 stall  input  1  hazard-unit stall; IF/ID must hold.
REQ-008 redirect  input  1  taken branch/jump; flush and load branch_target.
REQ-009 branch_target  input  32  redirect destination, valid when redirect=1.
REQ-010 imem_req  output  1  instruction memory request.
REQ-011 imem_addr  output  32  request address; stable while imem_req=1.
REQ-012 imem_ready  input  1  data valid on imem_rdata; completes request.
REQ-013 imem_rdata  input  32  fetched instruction.
REQ-014 if_id_instr / if_id_pc / if_id_pc4  output  32 each  IF/ID register: instruction, its PC, PC+4.
REQ-015 if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-016 fetch_cnt  output  32  instructions delivered into IF/ID.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, HOLD, DISCARD.
REQ-018 IDLE: imem_req=0, next_PC=PC; next cycle -> WAIT, latch req_addr=PC.
REQ-019 WAIT: imem_req=1, imem_addr=req_addr; req_addr SHALL not change while imem_req=1 and imem_ready=0.
REQ-020 WAIT, imem_ready=1, stall=0, redirect=0: load IF/ID {imem_rdata, req_addr, req_addr+4, valid=1}; next_PC=PC+4; fetch_cnt+1; stay WAIT, req_addr<=PC+4.
REQ-021 WAIT, imem_ready=1, stall=1, redirect=0: capture imem_rdata into skid register; IF/ID held; next_PC=PC; -> HOLD; imem_req=0 in HOLD.
REQ-022 HOLD, stall=0, redirect=0: load IF/ID from skid (valid=1, pc=req_addr); next_PC=PC+4; fetch_cnt+1; -> WAIT, req_addr<=PC+4.
REQ-023 WAIT, imem_ready=0: next_PC=PC; if stall=0 IF/ID loads bubble (if_id_valid=0, instr=NOP_INSTR); if stall=1 IF/ID held.
REQ-024 redirect=1 SHALL take priority over stall and imem_ready in every state: next_PC=branch_target; IF/ID cleared to bubble; skid discarded; fetch_cnt unchanged.
REQ-025 redirect in WAIT with imem_ready=0 -> DISCARD (request kept, old imem_addr held); with imem_ready=1 -> data dropped, stay WAIT, req_addr<=branch_target.
REQ-026 redirect in HOLD or IDLE -> WAIT, req_addr<=branch_target.
REQ-027 DISCARD: imem_req=1, old imem_addr; on imem_ready data dropped, -> WAIT, req_addr<=PC; next_PC=PC unless a further redirect (then next_PC=branch_target, stay DISCARD until ready).
REQ-028 PC+4 and req_addr+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-029 fetch_cnt SHALL wrap 32'hFFFF_FFFF -> 0.
REQ-030 Instruction order SHALL be preserved; no instruction delivered twice or skipped absent redirect.

Reset
REQ-031 reset=0 SHALL immediately force: state IDLE, imem_req=0, imem_addr=0, req_addr=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0, if_id_valid=0, fetch_cnt=0, skid cleared, next_PC=RESET_PC.
REQ-032 Reset asserted mid-request SHALL abandon the request; any imem_ready during reset is ignored.
REQ-033 First request after release SHALL be issued one cycle after reaching IDLE, to the PC then held by prog_counter.

Verification
REQ-034 Reset release, PC=0, imem_ready one cycle after each req -> if_id_pc sequence 0,4,8,12, all valid, fetch_cnt=4.
REQ-035 imem_ready held low 3 cycles at PC=8 -> imem_addr=8 stable, next_PC=8, 3 bubbles, then if_id_pc=8.
REQ-036 stall=1 for 2 cycles coincident with ready for PC=4 -> IF/ID holds PC=0 entry, skid absorbs 4; stall drop -> if_id_pc=4 next edge, no loss/duplication.
REQ-037 redirect to 0x100 while request to 0x10 pending -> imem_addr stays 0x10 until ready, data dropped, next request 0x100, if_id_valid=0 in between.
REQ-038 PC=32'hFFFF_FFFC fetched -> if_id_pc4=0, next request address 0.
REQ-039 reset=0 asserted between clock edges during WAIT -> all outputs reach reset values without a clock edge.
